// File: rtl/video_rx_if.sv
// Pin bundle between a PET video source and the video_rx decoder.
interface video_rx_if;
  logic       pixel_en;
  logic       video;
  logic       h_sync;
  logic       v_sync;
  logic [7:0] pixel_byte;
  logic       byte_valid;
  logic [6:0] col;
  logic [9:0] row;
  logic [9:0] h_total;
  logic [9:0] v_total;
  logic       locked;

  modport master (
    output pixel_en, video, h_sync, v_sync,
    input  pixel_byte, byte_valid, col, row, h_total, v_total, locked
  );

  modport slave (
    input  pixel_en, video, h_sync, v_sync,
    output pixel_byte, byte_valid, col, row, h_total, v_total, locked
  );
endinterface

// File: rtl/video_rx.sv
// PET video stream decoder: recovers line/frame position and deserializes active pixels into bytes.
// Optional line/frame timing measurement is enabled with VIDEO_RX_MEASURE_EN.
module video_rx #(
  parameter int unsigned H_START = 16,
  parameter int unsigned H_CHARS = 40,
  parameter int unsigned V_START = 2,
  parameter int unsigned V_LINES = 200
) (
  input  logic       clk16,
  input  logic       reset_n,
  video_rx_if.slave  vid
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned H_END = H_START + 8 * H_CHARS;
  localparam int unsigned V_END = V_START + V_LINES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {HUNT, RUN} state_t;

  state_t           r_state;
  logic             r_hs;
  logic             r_vs;
  logic [CNT_W-1:0] r_px;
  logic [CNT_W-1:0] r_ln;
  logic [6:0]       r_shift;
  logic [2:0]       r_bits;
  logic [7:0]       r_pixel_byte;
  logic             r_byte_valid;
  logic [6:0]       r_col;
  logic [9:0]       r_row;
  logic             r_locked;

  logic             w_h_fall;
  logic             w_v_fall;
  logic [CNT_W-1:0] w_px_cur;
  logic [CNT_W-1:0] w_ln_cur;
  logic             w_cap;
  logic [2:0]       w_bits;
  logic [7:0]       w_byte;
  logic [6:0]       w_col;
  logic [9:0]       w_row;

  // Position of the pixel sampled this cycle; a v_sync fall overrides a same-cycle h_sync fall.
  assign w_h_fall = r_hs & ~vid.h_sync;
  assign w_v_fall = r_vs & ~vid.v_sync;
  assign w_px_cur = w_h_fall ? '0 : ((r_px == CNT_MAX) ? r_px : r_px + CNT_W'(1));
  assign w_ln_cur = w_v_fall ? '0 :
                    ((w_h_fall && (r_ln != CNT_MAX)) ? r_ln + CNT_W'(1) : r_ln);

  assign w_cap  = (r_state == RUN) &&
                  (32'(w_px_cur) >= H_START) && (32'(w_px_cur) < H_END) &&
                  (32'(w_ln_cur) >= V_START) && (32'(w_ln_cur) < V_END);
  assign w_bits = w_h_fall ? 3'd0 : r_bits;
  assign w_byte = {r_shift, vid.video};
  assign w_col  = 7'((32'(w_px_cur) - H_START) >> 3);
  assign w_row  = 10'(32'(w_ln_cur) - V_START);

`ifdef VIDEO_RX_MEASURE_EN
  logic [CNT_W-1:0] r_h_total;
  logic [CNT_W-1:0] r_v_total;
  logic             r_h_ok;
  logic             r_v_ok;
  logic [CNT_W-1:0] w_h_meas;
  logic [CNT_W-1:0] w_v_meas;
  logic             w_h_ok;
  logic             w_v_ok;

  // A measurement from a saturated counter never counts as a match.
  assign w_h_meas = r_px + CNT_W'(1);
  assign w_v_meas = r_ln + CNT_W'(1);
  assign w_h_ok   = w_h_fall ? ((w_h_meas == r_h_total) && (r_px != CNT_MAX)) : r_h_ok;
  assign w_v_ok   = w_v_fall ? ((w_v_meas == r_v_total) && (r_ln != CNT_MAX)) : r_v_ok;

  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      r_h_total <= '0;
      r_v_total <= '0;
      r_h_ok    <= 1'b0;
      r_v_ok    <= 1'b0;
    end else if (vid.pixel_en) begin
      r_h_ok <= w_h_ok;
      r_v_ok <= w_v_ok;
      if (w_h_fall) r_h_total <= w_h_meas;
      if (w_v_fall) r_v_total <= w_v_meas;
    end
  end

  assign vid.h_total = r_h_total;
  assign vid.v_total = r_v_total;
`else
  assign vid.h_total = '0;
  assign vid.v_total = '0;
`endif

  // Sync tracking, capture state and registered outputs.
  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= HUNT;
      r_hs         <= 1'b0;
      r_vs         <= 1'b0;
      r_px         <= '0;
      r_ln         <= '0;
      r_shift      <= '0;
      r_bits       <= '0;
      r_pixel_byte <= '0;
      r_byte_valid <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_locked     <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (vid.pixel_en) begin
        r_hs   <= vid.h_sync;
        r_vs   <= vid.v_sync;
        r_px   <= w_px_cur;
        r_ln   <= w_ln_cur;
        r_bits <= w_bits;
        if (w_v_fall) r_state <= RUN;
`ifdef VIDEO_RX_MEASURE_EN
        r_locked <= ((r_state == RUN) || w_v_fall) && w_h_ok && w_v_ok;
`else
        r_locked <= (r_state == RUN) || w_v_fall;
`endif
        if (w_cap) begin
          r_shift <= w_byte[6:0];
          r_bits  <= w_bits + 3'd1;
          if (w_bits == 3'd7) begin
            r_pixel_byte <= w_byte;
            r_col        <= w_col;
            r_row        <= w_row;
            r_byte_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign vid.pixel_byte = r_pixel_byte;
  assign vid.byte_valid = r_byte_valid;
  assign vid.col        = r_col;
  assign vid.row        = r_row;
  assign vid.locked     = r_locked;

endmodule
